multi_strober: RTL and testbench

Parametrised multi-channel strobe generator: each channel synchronises an asynchronous level input, detects edges per a runtime-selectable mode, and emits single-cycle strobes, with optional auto-repeat while the level is held high. It supersedes the single-channel rising-edge strober in button, trigger and status-change paths, where several inputs share one clock domain.

---
 rtl/strober_pkg.sv | 26 ++
 rtl/multi_strober_if.sv | 29 ++
 rtl/strober_channel.sv | 130 +++++++++++++
 rtl/multi_strober.sv | 38 +++
 tb/tb_multi_strober.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/strober_pkg.sv
// Shared constants for the multi-channel strobe generator: edge-mode encodings,
// FSM state codes and the repeat-counter width helper.
package strober_pkg;

    localparam int unsigned MODE_W  = 2;
    localparam int unsigned STATE_W = 2;

    localparam logic [MODE_W-1:0] MODE_OFF  = 2'b00;
    localparam logic [MODE_W-1:0] MODE_RISE = 2'b01;
    localparam logic [MODE_W-1:0] MODE_FALL = 2'b10;
    localparam logic [MODE_W-1:0] MODE_BOTH = 2'b11;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_HOLD   = 2'd1;
    localparam state_t ST_REPEAT = 2'd2;

    // Counter must hold values up to max(hold, repeat); never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned rep);
        int unsigned mx;
        mx = (hold > rep) ? hold : rep;
        return (mx == 0) ? 1 : $clog2(mx + 1);
    endfunction

endpackage

// File: rtl/multi_strober_if.sv
// Level inputs, per-channel mode selects and strobe outputs of the multi-channel strober.
interface multi_strober_if #(
    parameter int unsigned CHANNELS = 4
);
    import strober_pkg::*;

    logic [CHANNELS-1:0]        signal;
    logic [MODE_W*CHANNELS-1:0] mode;
    logic [CHANNELS-1:0]        strobe;
    logic [CHANNELS-1:0]        strobe_dir;
    logic                       strobe_any;

    modport master (
        output signal,
        output mode,
        input  strobe,
        input  strobe_dir,
        input  strobe_any
    );

    modport slave (
        input  signal,
        input  mode,
        output strobe,
        output strobe_dir,
        output strobe_any
    );

endinterface

// File: rtl/strober_channel.sv
// One strobe channel: synchroniser, previous-level register, edge detect and
// IDLE/HOLD/REPEAT auto-repeat FSM with registered strobe outputs.
module strober_channel
    import strober_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned HOLD_CYCLES   = 0,
    parameter int unsigned REPEAT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              signal,
    input  logic [MODE_W-1:0] mode,
    output logic              strobe,
    output logic              strobe_dir
);

    localparam int unsigned   CW       = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] REP_END  = CW'(REPEAT_CYCLES);
    localparam bit            HOLD_EN  = (HOLD_CYCLES > 0);

    logic          lvl;
    logic          prev;
    logic          rise;
    logic          fall;
    logic          rise_en;
    logic          fall_en;
    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] cnt_end;
    logic          strobe_n;
    logic          dir_n;

    // Synchroniser chain; zero stages means the input is already in this clock domain.
    if (SYNC_STAGES == 0) begin : g_bypass
        assign lvl = signal;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= '0;
            end else begin
                sync_q[0] <= signal;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign lvl = sync_q[SYNC_STAGES-1];
    end

    assign rise    = lvl & ~prev;
    assign fall    = ~lvl & prev;
    assign rise_en = (mode == MODE_RISE) || (mode == MODE_BOTH);
    assign fall_en = (mode == MODE_FALL) || (mode == MODE_BOTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev       <= 1'b0;
            state      <= ST_IDLE;
            cnt        <= '0;
            strobe     <= 1'b0;
            strobe_dir <= 1'b0;
        end else begin
            prev       <= lvl;
            state      <= state_n;
            cnt        <= cnt_n;
            strobe     <= strobe_n;
            strobe_dir <= dir_n;
        end
    end

    // Next state; the repeat strobe fires on the cycle the counter would reach its limit.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        strobe_n = 1'b0;
        dir_n    = 1'b0;
        cnt_inc  = cnt + CW'(1);
        cnt_end  = (state == ST_HOLD) ? HOLD_END : REP_END;

        if (mode == MODE_OFF) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_n = '0;
                    if (rise && rise_en) begin
                        strobe_n = 1'b1;
                        dir_n    = 1'b1;
                        if (HOLD_EN) begin
                            state_n = ST_HOLD;
                        end
                    end else if (fall && fall_en) begin
                        strobe_n = 1'b1;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (!lvl) begin
                        state_n  = ST_IDLE;
                        cnt_n    = '0;
                        strobe_n = fall && fall_en;
                    end else if (!rise_en) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else if (cnt_inc == cnt_end) begin
                        strobe_n = 1'b1;
                        dir_n    = 1'b1;
                        state_n  = ST_REPEAT;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_strober.sv
// Multi-channel strobe generator: one independent strober_channel per input,
// plus the combined strobe_any flag.
module multi_strober
    import strober_pkg::*;
#(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned HOLD_CYCLES   = 0,
    parameter int unsigned REPEAT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset,
    multi_strober_if.slave bus
);

    logic [CHANNELS-1:0] strobe_v;
    logic [CHANNELS-1:0] dir_v;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        strober_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .signal    (bus.signal[i]),
            .mode      (bus.mode[MODE_W*i +: MODE_W]),
            .strobe    (strobe_v[i]),
            .strobe_dir(dir_v[i])
        );
    end

    assign bus.strobe     = strobe_v;
    assign bus.strobe_dir = dir_v;
    assign bus.strobe_any = |strobe_v;

endmodule

// File: tb/tb_multi_strober.sv
// Directed bench for multi_strober: 2 channels, 2 sync stages, hold 8, repeat 4.
module tb_multi_strober;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0;
    int t2;
    int dir_bad = 0;

    int   ev_ch[$];
    int   ev_t[$];
    logic ev_dir[$];
    int   any_t[$];

    int exp3[7] = '{3, 11, 15, 19, 23, 27, 31};

    multi_strober_if #(.CHANNELS(2)) bus ();

    multi_strober #(
        .CHANNELS     (2),
        .SYNC_STAGES  (2),
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n cycles, logging every strobe (channel, cycle, direction) 1ns after the edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int c = 0; c < 2; c++) begin
                if (bus.strobe[c]) begin
                    ev_ch.push_back(c);
                    ev_t.push_back(cyc);
                    ev_dir.push_back(bus.strobe_dir[c]);
                end
            end
            if (bus.strobe_any) any_t.push_back(cyc);
            if ((bus.strobe_dir & ~bus.strobe) != 2'b00) dir_bad++;
        end
    endtask

    task automatic clr();
        ev_ch.delete();
        ev_t.delete();
        ev_dir.delete();
        any_t.delete();
    endtask

    function automatic int ev_at(input int i);
        return (i < ev_t.size()) ? ev_t[i] : -1000;
    endfunction

    function automatic logic dir_at(input int i);
        return (i < ev_dir.size()) ? ev_dir[i] : 1'bx;
    endfunction

    function automatic int ch_at(input int i);
        return (i < ev_ch.size()) ? ev_ch[i] : -1;
    endfunction

    function automatic int any_at(input int i);
        return (i < any_t.size()) ? any_t[i] : -1000;
    endfunction

    initial begin
        bus.signal = 2'b00;
        bus.mode   = 4'b0000;
        run(2);
        check("rst_strobe", 32'(bus.strobe), 32'd0);
        check("rst_dir", 32'(bus.strobe_dir), 32'd0);
        check("rst_any", 32'(bus.strobe_any), 32'd0);
        reset = 1'b0;
        run(3);

        // ch0 rising only, 3-cycle pulse
        clr();
        bus.mode   = 4'b0001;
        t0         = cyc;
        bus.signal = 2'b01;
        run(3);
        bus.signal = 2'b00;
        run(12);
        check("t1_count", 32'(ev_t.size()), 32'd1);
        check("t1_time", 32'(ev_at(0) - t0), 32'd3);
        check("t1_dir", 32'(dir_at(0)), 32'd1);

        // ch1 both edges, 5-cycle pulse
        clr();
        bus.mode   = 4'b1100;
        t0         = cyc;
        bus.signal = 2'b10;
        run(5);
        bus.signal = 2'b00;
        run(12);
        check("t2_count", 32'(ev_t.size()), 32'd2);
        check("t2_ch", 32'(ch_at(0)), 32'd1);
        check("t2_rise_t", 32'(ev_at(0) - t0), 32'd3);
        check("t2_rise_dir", 32'(dir_at(0)), 32'd1);
        check("t2_fall_t", 32'(ev_at(1) - t0), 32'd8);
        check("t2_fall_dir", 32'(dir_at(1)), 32'd0);
        check("t2_any_count", 32'(any_t.size()), 32'd2);
        check("t2_any_0", 32'(any_at(0) - t0), 32'd3);
        check("t2_any_1", 32'(any_at(1) - t0), 32'd8);

        // ch0 held high 30 cycles: hold then auto-repeat
        clr();
        bus.mode   = 4'b0001;
        t0         = cyc;
        bus.signal = 2'b01;
        run(30);
        bus.signal = 2'b00;
        run(15);
        check("t3_count", 32'(ev_t.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t3_time%0d", i), 32'(ev_at(i) - t0), 32'(exp3[i]));
            check($sformatf("t3_dir%0d", i), 32'(dir_at(i)), 32'd1);
        end

        // high at reset release, then reset asserted during repeat
        reset      = 1'b1;
        bus.mode   = 4'b0001;
        bus.signal = 2'b01;
        run(3);
        reset = 1'b0;
        clr();
        t0 = cyc;
        run(15);
        check("t4_rep_hi", 32'(bus.strobe[0]), 32'd1);
        check("t4_count", 32'(ev_t.size()), 32'd3);
        check("t4_first", 32'(ev_at(0) - t0), 32'd3);
        check("t4_rep1", 32'(ev_at(1) - t0), 32'd11);
        check("t4_rep2", 32'(ev_at(2) - t0), 32'd15);
        reset = 1'b1;
        #1;
        check("t4_async_strobe", 32'(bus.strobe), 32'd0);
        check("t4_async_any", 32'(bus.strobe_any), 32'd0);
        check("t4_async_dir", 32'(bus.strobe_dir), 32'd0);
        bus.signal = 2'b00;
        run(3);
        reset = 1'b0;
        clr();
        run(10);
        check("t4_quiet", 32'(ev_t.size()), 32'd0);

        // mode 01 -> 00 during hold, then 00 -> 10 and release
        clr();
        bus.mode   = 4'b0001;
        t0         = cyc;
        bus.signal = 2'b01;
        run(5);
        bus.mode = 4'b0000;
        run(20);
        bus.mode = 4'b0010;
        run(2);
        t2         = cyc;
        bus.signal = 2'b00;
        run(8);
        check("t5_count", 32'(ev_t.size()), 32'd2);
        check("t5_rise_t", 32'(ev_at(0) - t0), 32'd3);
        check("t5_fall_t", 32'(ev_at(1) - t2), 32'd3);
        check("t5_fall_dir", 32'(dir_at(1)), 32'd0);

        // simultaneous rise on both channels
        clr();
        bus.mode   = 4'b1101;
        bus.signal = 2'b11;
        run(3);
        check("t6_strobe", 32'(bus.strobe), 32'd3);
        check("t6_dir", 32'(bus.strobe_dir), 32'd3);
        check("t6_any", 32'(bus.strobe_any), 32'd1);
        bus.signal = 2'b00;
        run(8);

        check("dir_only_with_strobe", 32'(dir_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
